// File: rtl/cmd_matcher_if.sv
// cmd_matcher byte-in / pulse-out bundle.
// master drives the received bytes, slave produces the pulses.
interface cmd_matcher_if #(
    parameter int NUM_CMD = 4,
    parameter int IDW     = 2
) ();
    logic               recv_valid;
    logic [7:0]         recv_data;
    logic               hit;
    logic [IDW-1:0]     cmd_id;
    logic [NUM_CMD-1:0] cmd_hot;
    logic               miss;
    logic               timeout;
    logic               busy;

    modport master (
        output recv_valid, recv_data,
        input  hit, cmd_id, cmd_hot, miss, timeout, busy
    );

    modport slave (
        input  recv_valid, recv_data,
        output hit, cmd_id, cmd_hot, miss, timeout, busy
    );
endinterface

// File: rtl/cmd_matcher.sv
// Line-based keyword recogniser on the UART RX byte stream.
// One registered hit/miss/timeout pulse per completed or dropped line.
module cmd_matcher #(
    parameter int NUM_CMD = 4,
    parameter int MAX_LEN = 8,
    parameter logic [NUM_CMD*MAX_LEN*8-1:0] CMD_STR = {
        64'h00000074_65736572,
        64'h00000000_00006f67,
        64'h00000000_706f7473,
        64'h00000074_72617473
    },
    parameter logic [7:0] TERM      = 8'h0D,
    parameter bit         IGNORE_LF = 1'b1,
    parameter bit         CASE_FOLD = 1'b1,
    parameter int         TIMEOUT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    cmd_matcher_if.slave    bus
);
    localparam int IDW  = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [NUM_CMD-1:0] cand_q, cand_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               to_q, to_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [NUM_CMD-1:0] hot_q, hot_d;
    logic               busy_q, busy_d;

    logic [LW-1:0]      klen [NUM_CMD];
    logic [NUM_CMD-1:0] match;
    logic               found;
    logic               byte_ok;
    logic [7:0]         kc;

    function automatic logic [7:0] fold(input logic [7:0] c);
        if (CASE_FOLD && c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
        return c;
    endfunction

    function automatic logic [7:0] key_char(input int i, input int j);
        return CMD_STR[(i*MAX_LEN + j)*8 +: 8];
    endfunction

    // Keyword lengths: position of the first NUL, else MAX_LEN.
    always_comb begin
        for (int i = 0; i < NUM_CMD; i++) begin
            klen[i] = LW'(MAX_LEN);
            for (int j = MAX_LEN - 1; j >= 0; j--) begin
                if (key_char(i, j) == 8'h00) klen[i] = LW'(j);
            end
        end
    end

    // Next-state: candidate narrowing, line termination and idle timer.
    always_comb begin
        cand_d  = cand_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        idle_d  = idle_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        to_d    = 1'b0;
        id_d    = '0;
        hot_d   = '0;
        match   = '0;
        found   = 1'b0;
        kc      = 8'h00;
        byte_ok = bus.recv_valid &&
                  !(IGNORE_LF && bus.recv_data == 8'h0A);

        if (byte_ok) begin
            idle_d = '0;
            if (bus.recv_data == TERM) begin
                for (int i = 0; i < NUM_CMD; i++) begin
                    match[i] = cand_q[i] && (klen[i] == len_q) && !ovf_q;
                end
                for (int i = 0; i < NUM_CMD; i++) begin
                    if (match[i] && !found) begin
                        found = 1'b1;
                        id_d  = IDW'(i);
                    end
                end
                hit_d  = found;
                miss_d = !found;
                hot_d  = found ? (NUM_CMD'(1) << id_d) : '0;
                if (!found) id_d = '0;
                cand_d = '1;
                len_d  = '0;
                ovf_d  = 1'b0;
            end else if (len_q < LW'(MAX_LEN)) begin
                for (int i = 0; i < NUM_CMD; i++) begin
                    kc = fold(key_char(i, int'(len_q)));
                    cand_d[i] = cand_q[i] && (kc == fold(bus.recv_data))
                                && (kc != 8'h00);
                end
                len_d = len_q + LW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (!bus.recv_valid && TIMEOUT > 0 && len_q != '0) begin
            if (idle_q == TW'(TLIM)) begin
                to_d   = 1'b1;
                idle_d = '0;
                cand_d = '1;
                len_d  = '0;
                ovf_d  = 1'b0;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end

        busy_d = (len_d != '0) || ovf_d;
    end

    // State and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= '1;
            len_q  <= '0;
            ovf_q  <= 1'b0;
            idle_q <= '0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            to_q   <= 1'b0;
            id_q   <= '0;
            hot_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cand_q <= cand_d;
            len_q  <= len_d;
            ovf_q  <= ovf_d;
            idle_q <= idle_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            to_q   <= to_d;
            id_q   <= id_d;
            hot_q  <= hot_d;
            busy_q <= busy_d;
        end
    end

    assign bus.hit     = hit_q;
    assign bus.miss    = miss_q;
    assign bus.timeout = to_q;
    assign bus.cmd_id  = id_q;
    assign bus.cmd_hot = hot_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_cmd_matcher.sv
// Randomised and directed bench for cmd_matcher (TIMEOUT=16).
// Reference model works on whole lines as byte strings.
module tb_cmd_matcher;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmd_matcher_if #(.NUM_CMD(4), .IDW(2)) bus ();

    cmd_matcher #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    string        kw [4];
    byte unsigned line [$];
    byte unsigned stim [$];
    int           idle;
    logic         e_hit, e_miss, e_to, e_busy;
    logic [1:0]   e_id;
    logic [3:0]   e_hot;

    function automatic byte unsigned fold(byte unsigned c);
        if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
        return c;
    endfunction

    function automatic int lookup();
        bit same;
        if (line.size() > 8) return -1;
        for (int i = 0; i < 4; i++) begin
            if (kw[i].len() == line.size()) begin
                same = 1'b1;
                for (int j = 0; j < line.size(); j++)
                    if (fold(line[j]) != fold(byte'(kw[i][j]))) same = 1'b0;
                if (same) return i;
            end
        end
        return -1;
    endfunction

    function automatic void model_reset();
        line.delete();
        idle   = 0;
        e_hit  = 0;
        e_miss = 0;
        e_to   = 0;
        e_busy = 0;
        e_id   = 0;
        e_hot  = 0;
    endfunction

    function automatic void model(bit v, byte unsigned d);
        int k;
        e_hit  = 0;
        e_miss = 0;
        e_to   = 0;
        e_id   = 0;
        e_hot  = 0;
        if (v) begin
            if (d != 8'h0A) begin
                idle = 0;
                if (d == 8'h0D) begin
                    k = lookup();
                    if (k >= 0) begin
                        e_hit = 1;
                        e_id  = 2'(k);
                        e_hot = 4'(1 << k);
                    end else begin
                        e_miss = 1;
                    end
                    line.delete();
                end else if (line.size() <= 8) begin
                    line.push_back(d);
                end
            end
        end else if (line.size() > 0) begin
            idle++;
            if (idle == 16) begin
                e_to = 1;
                idle = 0;
                line.delete();
            end
        end
        e_busy = (line.size() != 0);
    endfunction

    function automatic logic [9:0] obs();
        return {bus.hit, bus.miss, bus.timeout, bus.cmd_id,
                bus.cmd_hot, bus.busy};
    endfunction

    function automatic logic [9:0] expv();
        return {e_hit, e_miss, e_to, e_id, e_hot, e_busy};
    endfunction

    task automatic drive(bit v, byte unsigned d);
        bus.recv_valid = v;
        bus.recv_data  = d;
        model(v, d);
        @(posedge clk);
        #1;
        bus.recv_valid = 1'b0;
    endtask

    function automatic void load(string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(byte'(s[i]));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.recv_valid = 1'b0;
        bus.recv_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (obs() !== expv())
            $display("FAIL reset: got %b want %b", obs(), expv());
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_start();
        int pulses = 0;
        load("start\r");
        while (stim.size() > 0) begin
            drive(1, stim.pop_front());
            n_chk++;
            if (obs() !== expv())
                $display("FAIL start: got %b want %b", obs(), expv());
            else n_pass++;
        end
        n_chk++;
        if ({bus.hit, bus.cmd_id, bus.cmd_hot} !== 7'b1_00_0001)
            $display("FAIL start_hit: got %b want 1000001",
                     {bus.hit, bus.cmd_id, bus.cmd_hot});
        else n_pass++;
        drive(0, 0);
        n_chk++;
        if (bus.hit !== 1'b0)
            $display("FAIL start_one_cycle: got %b want 0", bus.hit);
        else n_pass++;
    endtask

    task automatic test_fold_lf();
        load("STOP\r\n\n");
        while (stim.size() > 0) begin
            drive(1, stim.pop_front());
            n_chk++;
            if (obs() !== expv())
                $display("FAIL fold_lf: got %b want %b", obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_prefix();
        load("st\rstops\r\r");
        while (stim.size() > 0) begin
            drive(1, stim.pop_front());
            n_chk++;
            if (obs() !== expv())
                $display("FAIL prefix: got %b want %b", obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        load("resetgo12\rgo\r");
        while (stim.size() > 0) begin
            drive(1, stim.pop_front());
            n_chk++;
            if (obs() !== expv())
                $display("FAIL overflow: got %b want %b", obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        load("sta");
        while (stim.size() > 0) drive(1, stim.pop_front());
        for (int c = 0; c < 20; c++) begin
            drive(0, 0);
            pulses += bus.timeout;
            n_chk++;
            if (obs() !== expv())
                $display("FAIL timeout: got %b want %b", obs(), expv());
            else n_pass++;
        end
        n_chk++;
        if (pulses != 1 || bus.busy !== 1'b0)
            $display("FAIL timeout_once: got %0d/%b want 1/0",
                     pulses, bus.busy);
        else n_pass++;
        load("sta");
        while (stim.size() > 0) drive(1, stim.pop_front());
        repeat (15) drive(0, 0);
        load("rx\rgo\r");
        while (stim.size() > 0) begin
            drive(1, stim.pop_front());
            n_chk++;
            if (obs() !== expv())
                $display("FAIL timeout_race: got %b want %b", obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_rst_midline();
        load("sto");
        while (stim.size() > 0) drive(1, stim.pop_front());
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (obs() !== expv())
            $display("FAIL rst_mid: got %b want %b", obs(), expv());
        else n_pass++;
        rst = 1'b0;
        load("p\r");
        while (stim.size() > 0) begin
            drive(1, stim.pop_front());
            n_chk++;
            if (obs() !== expv())
                $display("FAIL rst_line: got %b want %b", obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        load("go\rgo\r\r\rgo\r");
        while (stim.size() > 0) begin
            drive(1, stim.pop_front());
            n_chk++;
            if (obs() !== expv())
                $display("FAIL b2b: got %b want %b", obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        string       w;
        int          r, n;
        byte unsigned c;
        for (int l = 0; l < 200; l++) begin
            w = kw[$urandom_range(0, 3)];
            r = $urandom_range(0, 5);
            if (r <= 1 || r == 5) n = w.len();
            else if (r == 2) n = $urandom_range(0, w.len() - 1);
            else if (r == 3) n = w.len() + 1;
            else n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++) begin
                if (r == 4 || j >= w.len()) c = 8'(97 + $urandom_range(0, 25));
                else c = byte'(w[j]);
                if ($urandom_range(0, 1) == 1) c = c & 8'hDF;
                stim.push_back(c);
                if (r == 5 && $urandom_range(0, 3) == 0) stim.push_back(8'h0A);
            end
            stim.push_back(8'h0D);
            if ($urandom_range(0, 1) == 1) stim.push_back(8'h0A);
            while (stim.size() > 0) begin
                if ($urandom_range(0, 7) == 0) n = $urandom_range(1, 4);
                else if ($urandom_range(0, 49) == 0) n = $urandom_range(14, 18);
                else n = 0;
                for (int g = 0; g < n; g++) begin
                    drive(0, 0);
                    n_chk++;
                    if (obs() !== expv())
                        $display("FAIL rand_idle: got %b want %b",
                                 obs(), expv());
                    else n_pass++;
                end
                drive(1, stim.pop_front());
                n_chk++;
                if (obs() !== expv())
                    $display("FAIL rand_byte: got %b want %b", obs(), expv());
                else n_pass++;
            end
        end
    endtask

    initial begin
        kw[0] = "start";
        kw[1] = "stop";
        kw[2] = "go";
        kw[3] = "reset";
        test_reset();
        test_start();
        test_fold_lf();
        test_prefix();
        test_overflow();
        test_timeout();
        test_rst_midline();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
